// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- 16-bit sequential add/sub(/compare) unit built around one shared
// 4-bit nibble adder. One nibble is processed per clock, least significant
// nibble first, with the carry chained through a carry register.
//
// Configuration macro:
//   ALU_SEQ_CMP_EN  when defined, op 3'b010 is compare (flags as sub, sum = 0);
//                   when undefined, op 3'b010 is illegal and no compare logic
//                   is built.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous reset, active-high
//   req_valid     request present
//   req_ready     block can accept a request (state == IDLE)
//   req_op[2:0]   000 add, 001 sub, 010 compare (optional), others illegal
//   req_a[15:0]   operand A
//   req_b[15:0]   operand B
//   rsp_valid     result present (state == DONE)
//   rsp_ready     consumer takes result
//   rsp_sum[15:0] result
//   rsp_carry     carry out of bit 15 (sub/compare: 1 = no borrow)
//   rsp_zero      result == 0
//   rsp_overflow  signed two's-complement overflow
//   rsp_err       illegal op
// -----------------------------------------------------------------------------
module alu_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_sum,
   output logic        rsp_carry,
   output logic        rsp_zero,
   output logic        rsp_overflow,
   output logic        rsp_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        carry_q, carry_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;       // B operand after the conditional inversion
   logic [15:0] res_q, res_d;   // result nibbles accumulated during RUN
   logic [15:0] sum_q, sum_d;
   logic        rc_q, rc_d;
   logic        zero_q, zero_d;
   logic        ovf_q, ovf_d;
   logic        err_q, err_d;
`ifdef ALU_SEQ_CMP_EN
   logic        cmp_q, cmp_d;
`endif

   // Request decode
   logic        op_legal;
   logic        op_sub_like;   // B inverted, carry-in 1
`ifdef ALU_SEQ_CMP_EN
   logic        op_cmp;
`endif

   always_comb begin
      op_legal    = 1'b0;
      op_sub_like = 1'b0;
`ifdef ALU_SEQ_CMP_EN
      op_cmp      = 1'b0;
`endif
      case (req_op)
         3'b000: op_legal = 1'b1;
         3'b001: begin
            op_legal    = 1'b1;
            op_sub_like = 1'b1;
         end
`ifdef ALU_SEQ_CMP_EN
         3'b010: begin
            op_legal    = 1'b1;
            op_sub_like = 1'b1;
            op_cmp      = 1'b1;
         end
`endif
         default: op_legal = 1'b0;
      endcase
   end

   // Nibble selection for the shared adder
   logic [3:0] a_nib_w [4];
   logic [3:0] b_nib_w [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_nib
         assign a_nib_w[gi] = a_q[gi*4 +: 4];
         assign b_nib_w[gi] = b_q[gi*4 +: 4];
      end
   endgenerate

   logic [3:0]  a_nib, b_nib;
   logic [4:0]  nib_sum;
   logic [15:0] final_res;

   assign a_nib     = a_nib_w[idx_q];
   assign b_nib     = b_nib_w[idx_q];
   assign nib_sum   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
   // Only meaningful while idx_q == 3: top nibble fresh from the adder.
   assign final_res = {nib_sum[3:0], res_q[11:0]};

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      rc_d    = rc_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
`ifdef ALU_SEQ_CMP_EN
      cmp_d   = cmp_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = op_sub_like ? ~req_b : req_b;
               carry_d = op_sub_like;
               idx_d   = 2'd0;
`ifdef ALU_SEQ_CMP_EN
               cmp_d   = op_cmp;
`endif
               if (op_legal) begin
                  state_d = RUN;
               end else begin
                  // Illegal op skips RUN and reports straight away.
                  state_d = DONE;
                  sum_d   = 16'h0000;
                  rc_d    = 1'b0;
                  zero_d  = 1'b0;
                  ovf_d   = 1'b0;
                  err_d   = 1'b1;
               end
            end
         end
         RUN: begin
            res_d[idx_q*4 +: 4] = nib_sum[3:0];
            carry_d             = nib_sum[4];
            idx_d               = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_d = DONE;
               rc_d    = nib_sum[4];
               zero_d  = (final_res == 16'h0000);
               ovf_d   = (a_q[15] == b_q[15]) && (nib_sum[3] != a_q[15]);
               err_d   = 1'b0;
`ifdef ALU_SEQ_CMP_EN
               sum_d   = cmp_q ? 16'h0000 : final_res;
`else
               sum_d   = final_res;
`endif
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= 2'd0;
         carry_q <= 1'b0;
         a_q     <= 16'h0000;
         b_q     <= 16'h0000;
         res_q   <= 16'h0000;
         sum_q   <= 16'h0000;
         rc_q    <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef ALU_SEQ_CMP_EN
         cmp_q   <= 1'b0;
`endif
      end else begin
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         rc_q    <= rc_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
`ifdef ALU_SEQ_CMP_EN
         cmp_q   <= cmp_d;
`endif
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign rsp_valid    = (state_q == DONE);
   assign rsp_sum      = sum_q;
   assign rsp_carry    = rc_q;
   assign rsp_zero     = zero_q;
   assign rsp_overflow = ovf_q;
   assign rsp_err      = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq. Expected responses
// are pushed onto a scoreboard queue when a request is driven and popped when
// the DUT presents rsp_valid.
// -----------------------------------------------------------------------------
module tb_alu_seq;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_sum;
   logic        rsp_carry;
   logic        rsp_zero;
   logic        rsp_overflow;
   logic        rsp_err;

   alu_seq dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_a        (req_a),
      .req_b        (req_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_sum      (rsp_sum),
      .rsp_carry    (rsp_carry),
      .rsp_zero     (rsp_zero),
      .rsp_overflow (rsp_overflow),
      .rsp_err      (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] sum;
      logic        carry;
      logic        zero;
      logic        ovf;
      logic        err;
      logic [3:0]  lat;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic [15:0] s, input logic c, input logic z,
                           input logic v, input logic e, input logic [3:0] lat);
      exp_t x;
      x.sum = s; x.carry = c; x.zero = z; x.ovf = v; x.err = e; x.lat = lat;
      exp_q.push_back(x);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic start_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      chk("accept_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_a     = ~a;   // later changes must not disturb the operation
      req_b     = ~b;
      req_op    = 3'b000;
   endtask

   // Called at the negedge after the accepting edge; waits for rsp_valid,
   // checks latency and response against the scoreboard head.
   task automatic wait_rsp(input string tag);
      int   edges;
      exp_t x;
      edges = 0;
      while (edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (rsp_valid) break;
      end
      if (!rsp_valid) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
      end else if (exp_q.size() == 0) begin
         chk({tag, "_unexpected"}, 32'd1, 32'd0);
      end else begin
         x = exp_q.pop_front();
         $display("rsp %s: sum=%h carry=%0d zero=%0d ovf=%0d err=%0d latency=%0d",
                  tag, rsp_sum, rsp_carry, rsp_zero, rsp_overflow, rsp_err, edges);
         chk({tag, "_latency"}, edges, {28'd0, x.lat});
         chk({tag, "_sum"},   {16'd0, rsp_sum},      {16'd0, x.sum});
         chk({tag, "_carry"}, {31'd0, rsp_carry},    {31'd0, x.carry});
         chk({tag, "_zero"},  {31'd0, rsp_zero},     {31'd0, x.zero});
         chk({tag, "_ovf"},   {31'd0, rsp_overflow}, {31'd0, x.ovf});
         chk({tag, "_err"},   {31'd0, rsp_err},      {31'd0, x.err});
      end
   endtask

   task automatic release_rsp(input string tag);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_idle_valid"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 3'b000;
      req_a     = 16'h0000;
      req_b     = 16'h0000;
      rsp_ready = 1'b0;

      // Reset state, with a request offered that must not be taken.
      @(negedge clk);
      req_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_flags", {27'd0, rsp_carry, rsp_zero, rsp_overflow, rsp_err, 1'b0}, 32'd0);
      chk("rst_rsp_sum",   {16'd0, rsp_sum}, 32'd0);
      req_valid = 1'b0;

      // First edge after reset release accepts: add 0x1234 + 0x0FCD.
      rst = 1'b0;
      push_exp(16'h2201, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      start_req(3'b000, 16'h1234, 16'h0FCD);
      chk("add1_run_ready", {31'd0, req_ready}, 32'd0);
      wait_rsp("add1");
      release_rsp("add1");

      // sub 0x8000 - 0x0001
      push_exp(16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4);
      start_req(3'b001, 16'h8000, 16'h0001);
      wait_rsp("sub1");
      release_rsp("sub1");

      // add 0xFFFF + 0x0001
      push_exp(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4);
      start_req(3'b000, 16'hFFFF, 16'h0001);
      wait_rsp("add2");
      release_rsp("add2");

      // op 010 with A = B = 5
`ifdef ALU_SEQ_CMP_EN
      push_exp(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4);
`else
      push_exp(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
`endif
      start_req(3'b010, 16'h0005, 16'h0005);
      wait_rsp("op010");
      release_rsp("op010");

      // op 111 is illegal in every build
      push_exp(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
      start_req(3'b111, 16'h1234, 16'h4321);
      wait_rsp("op111");
      release_rsp("op111");

      // Backpressure in DONE with a new request waiting.
      push_exp(16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      start_req(3'b000, 16'h1111, 16'h2222);
      wait_rsp("bp");
      req_op    = 3'b000;
      req_a     = 16'h0003;
      req_b     = 16'h0004;
      req_valid = 1'b1;
      push_exp(16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_hold_sum",   {16'd0, rsp_sum}, 32'h3333);
         chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
      chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_accepted", {31'd0, req_ready}, 32'd0);
      wait_rsp("bp_next");
      release_rsp("bp_next");

      // Reset during the 2nd RUN cycle aborts without a response.
      req_op    = 3'b000;
      req_a     = 16'h00FF;
      req_b     = 16'h0001;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_sum",   {16'd0, rsp_sum}, 32'd0);
      chk("abort_flags", {28'd0, rsp_carry, rsp_zero, rsp_overflow, rsp_err}, 32'd0);
      rst = 1'b0;
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
         end
         chk("abort_no_pulse", {31'd0, seen}, 32'd0);
      end

      push_exp(16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      start_req(3'b000, 16'h0001, 16'h0001);
      wait_rsp("post_abort");
      release_rsp("post_abort");

      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
